inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch front end: the requesting side of the instruction-memory read interface.
- Owns the program counter and drives a word address to the instruction memory, which returns the instruction combinationally in the same cycle.
- Captures each fetched instruction with its PC into a small FIFO and delivers it to decode over a valid/ready handshake.
- Handles redirects from the back end (branch or squash) by flushing the FIFO and reloading the PC.

Parameters:
- MEMI_SIZE_LOG, default `MEMI_SIZE_LOG: instruction-memory address width in words.
- INST_LEN, default `INST_LEN: instruction width in bits.
- FQ_DEPTH_LOG, default 2: log2 of the fetch-queue depth. Depth FQ_DEPTH = 2**FQ_DEPTH_LOG, at least 2 entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_addr  out  MEMI_SIZE_LOG  instruction-memory read address; always equals the pc register.
- resp_data  in  INST_LEN  instruction at req_addr, valid in the same cycle.
- redirect_valid  in  1  back-end redirect request.
- redirect_pc  in  MEMI_SIZE_LOG  new fetch address; sampled when redirect_valid=1.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  INST_LEN  instruction at the queue head.
- out_pc  out  MEMI_SIZE_LOG  PC of the queue-head instruction.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=0; queue read/write pointers and count cleared.
  - out_valid=0; out_inst and out_pc read as 0 while the queue is empty.
  - Reset asserted mid-operation discards all queued entries; no partial state survives.
- Fetch:
  - req_addr = pc, combinational.
  - do_enq = !redirect_valid && (count != FQ_DEPTH).
  - On do_enq, at the clock edge: write {pc, resp_data} at wptr, then pc <= pc+1.
  - pc wraps modulo 2**MEMI_SIZE_LOG: MEMI_SIZE-1 is followed by 0.
- Full: when count == FQ_DEPTH, no enqueue and pc holds.
  - No same-cycle enqueue-on-dequeue bypass when full. A freed slot is refilled on the following cycle. This keeps out_ready off any combinational path to req_addr.
- Dequeue:
  - out_valid = (count != 0); out_inst and out_pc come from the entry at rptr.
  - do_deq = out_valid && out_ready && !redirect_valid. On the edge, rptr advances.
  - out_ready is a don't-care while out_valid=0.
- Count update:
  - count += do_enq - do_deq.
  - Enqueue and dequeue in the same cycle, not full: count unchanged, both pointers advance.
  - Pointers are FQ_DEPTH_LOG bits and wrap naturally.
- Redirect (highest priority):
  - When redirect_valid=1, at the edge: pc <= redirect_pc, pointers and count cleared, no enqueue, no dequeue.
  - The handshake is ignored in that cycle even if out_valid and out_ready are both 1. Decode must not treat the head as consumed.
  - Back-to-back redirects: the last one wins.
  - First instruction from redirect_pc is enqueued on the cycle after the redirect and is visible at out_valid the cycle after that.
- Latency: an instruction fetched in cycle N is presented on out_* in cycle N+1.
- Steady-state throughput: 1 instruction per cycle when out_ready is held at 1.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- When defined:
  - Extra port fq_full_cnt, output, 16 bits.
  - Counts cycles with count == FQ_DEPTH and redirect_valid=0.
  - Saturates at 16'hFFFF; reset to 0 on rst.
  - Redirects do not clear it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with memory word k = k+16 and out_ready=1:
  - Cycle 0: out_valid=0, req_addr=0.
  - Cycle 1: out_valid=1, out_pc=0, out_inst=16.
  - Then one instruction per cycle: out_pc=1, 2, 3, …
- Hold out_ready=0 from reset, FQ_DEPTH=4:
  - pc reaches 4 and holds; count saturates at 4; req_addr stays 4.
  - Raise out_ready: entries pc 0..3 drain in order; the first refill (pc 4) appears 1 cycle after the first dequeue slot frees.
- Redirect at count=3 with out_valid=1 and out_ready=1, redirect_pc=5:
  - No entry consumed; next cycle out_valid=0.
  - The cycle after, out_pc=5.
- Wrap: redirect_pc = MEMI_SIZE-1 with out_ready=1 -> out_pc sequence MEMI_SIZE-1, 0, 1.
- Assert rst asynchronously mid-cycle with 2 entries queued -> out_valid falls immediately (before the next edge) and req_addr=0; after release, fetch restarts from 0.
- With FETCH_STALL_CNT_EN and out_ready=0 for 10 cycles after reset, depth 4 -> fq_full_cnt=6.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: instruction-memory read port, back-end redirect and decode handshake.
// MEMI_SIZE_LOG / INST_LEN fall back to 6 / 32 when the build does not define them.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 6
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

interface inst_fetch_if #(
  parameter int MEMI_SIZE_LOG = `MEMI_SIZE_LOG,
  parameter int INST_LEN      = `INST_LEN
);
  logic [MEMI_SIZE_LOG-1:0] req_addr;
  logic [INST_LEN-1:0]      resp_data;
  logic                     redirect_valid;
  logic [MEMI_SIZE_LOG-1:0] redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [INST_LEN-1:0]      out_inst;
  logic [MEMI_SIZE_LOG-1:0] out_pc;

  modport master (
    output req_addr,
    input  resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  req_addr,
    output resp_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Fetch front end: PC + fetch queue, one-cycle fetch-to-decode latency, refill of a freed slot
// one cycle after dequeue when full. Optional FETCH_STALL_CNT_EN adds the fq_full_cnt counter.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 6
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module inst_fetch #(
  parameter int MEMI_SIZE_LOG = `MEMI_SIZE_LOG,
  parameter int INST_LEN      = `INST_LEN,
  parameter int FQ_DEPTH_LOG  = 2
) (
  input  logic clk,
  input  logic rst,
  inst_fetch_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] fq_full_cnt
`endif
);
  localparam int FQ_DEPTH = 2**FQ_DEPTH_LOG;
  localparam logic [FQ_DEPTH_LOG:0] FQ_FULL = (FQ_DEPTH_LOG+1)'(FQ_DEPTH);

  logic [MEMI_SIZE_LOG-1:0] pc;
  logic [MEMI_SIZE_LOG-1:0] fq_pc   [FQ_DEPTH];
  logic [INST_LEN-1:0]      fq_inst [FQ_DEPTH];
  logic [FQ_DEPTH_LOG-1:0]  rptr, wptr;
  logic [FQ_DEPTH_LOG:0]    count;
  logic full, empty, do_enq, do_deq;

  assign full  = (count == FQ_FULL);
  assign empty = (count == '0);
  // Enqueue looks only at the registered count, so out_ready never reaches req_addr.
  assign do_enq = !bus.redirect_valid && !full;
  assign do_deq = !empty && bus.out_ready && !bus.redirect_valid;

  assign bus.req_addr  = pc;
  assign bus.out_valid = !empty;
  assign bus.out_inst  = empty ? '0 : fq_inst[rptr];
  assign bus.out_pc    = empty ? '0 : fq_pc[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_enq) begin
        wptr <= wptr + 1'b1;
        pc   <= pc + 1'b1;
      end
      if (do_deq) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      fq_pc[wptr]   <= pc;
      fq_inst[wptr] <= bus.resp_data;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_full_cnt <= '0;
    end else if (full && !bus.redirect_valid && (fq_full_cnt != 16'hFFFF)) begin
      fq_full_cnt <= fq_full_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model compared every cycle, plus literal checks.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 6
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module tb_inst_fetch;
  localparam int ML    = `MEMI_SIZE_LOG;
  localparam int IL    = `INST_LEN;
  localparam int DEPTH = 4;

  typedef struct {
    logic [ML-1:0] pc;
    logic [IL-1:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  inst_fetch_if #(.MEMI_SIZE_LOG(ML), .INST_LEN(IL)) bus ();

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] fq_full_cnt;
  inst_fetch #(.MEMI_SIZE_LOG(ML), .INST_LEN(IL), .FQ_DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fq_full_cnt(fq_full_cnt));
`else
  inst_fetch #(.MEMI_SIZE_LOG(ML), .INST_LEN(IL), .FQ_DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Instruction memory: word k holds k+16.
  always_comb bus.resp_data = IL'(bus.req_addr) + IL'(16);

  ent_t          q[$];
  logic [ML-1:0] m_pc;
  int            m_full_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = '0;
    m_full_cnt = 0;
  endtask

  // One cycle: drive inputs after the falling edge, compare, then advance the model across the rising edge.
  task automatic step(input logic rv, input logic [ML-1:0] rpc, input logic rdy);
    int  sz;
    bit  deq;
    @(negedge clk);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
    sz = q.size();
    check("req_addr", 64'(bus.req_addr), 64'(m_pc));
    check("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    check("out_pc", 64'(bus.out_pc), (sz != 0) ? 64'(q[0].pc) : 64'd0);
    check("out_inst", 64'(bus.out_inst), (sz != 0) ? 64'(q[0].inst) : 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("fq_full_cnt", 64'(fq_full_cnt), 64'(m_full_cnt));
`endif
    if (rv) begin
      q.delete();
      m_pc = rpc;
    end else begin
      if (sz == DEPTH && m_full_cnt != 16'hFFFF) m_full_cnt++;
      deq = (sz != 0) && rdy;
      if (deq) void'(q.pop_front());
      if (sz != DEPTH) begin
        q.push_back('{pc: m_pc, inst: IL'(m_pc) + IL'(16)});
        m_pc = m_pc + 1'b1;
      end
    end
  endtask

  // Applies reset while idle, checks the reset outputs, and releases it just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_req_addr", 64'(bus.req_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid0", 64'(bus.out_valid), 64'd0);
    check("rst_out_pc0", 64'(bus.out_pc), 64'd0);
    check("rst_out_inst0", 64'(bus.out_inst), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset release, streaming.
    step(0, '0, 1);
    check("A_c0_valid", 64'(bus.out_valid), 64'd0);
    check("A_c0_addr", 64'(bus.req_addr), 64'd0);
    step(0, '0, 1);
    check("A_c1_valid", 64'(bus.out_valid), 64'd1);
    check("A_c1_pc", 64'(bus.out_pc), 64'd0);
    check("A_c1_inst", 64'(bus.out_inst), 64'd16);
    for (int i = 1; i < 6; i++) begin
      step(0, '0, 1);
      check("A_stream_pc", 64'(bus.out_pc), 64'(i));
    end

    // Backpressure until full, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, '0, 0);
    step(0, '0, 0);
    check("B_addr_hold", 64'(bus.req_addr), 64'd4);
    check("B_valid", 64'(bus.out_valid), 64'd1);
`ifdef FETCH_STALL_CNT_EN
    check("B_full_cnt", 64'(fq_full_cnt), 64'd6);
`endif
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 1);
      check("B_drain_pc", 64'(bus.out_pc), 64'(i));
      if (i == 1) check("B_refill_addr", 64'(bus.req_addr), 64'd4);
    end

    // Redirect at count 3 while handshaking.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    step(1, ML'(5), 1);
    check("C_valid_before", 64'(bus.out_valid), 64'd1);
    check("C_pc_before", 64'(bus.out_pc), 64'd0);
    step(0, '0, 1);
    check("C_valid_after", 64'(bus.out_valid), 64'd0);
    check("C_addr_after", 64'(bus.req_addr), 64'd5);
    step(0, '0, 1);
    check("C_pc_new", 64'(bus.out_pc), 64'd5);

    // Wrap at the top of instruction memory.
    step(1, '1, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    check("D_wrap0", 64'(bus.out_pc), 64'((1 << ML) - 1));
    step(0, '0, 1);
    check("D_wrap1", 64'(bus.out_pc), 64'd0);
    step(0, '0, 1);
    check("D_wrap2", 64'(bus.out_pc), 64'd1);

    // Asynchronous reset with two entries queued.
    do_reset();
    step(0, '0, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    check("E_valid_pre", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("E_valid_async", 64'(bus.out_valid), 64'd0);
    check("E_addr_async", 64'(bus.req_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, '0, 1);
    step(0, '0, 1);
    check("E_restart_pc", 64'(bus.out_pc), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ML'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
